// File: rtl/regfile_dump.sv
// Register-file scan-out: walks addresses 0..NUM_REGS-1 and streams each word on a valid/ready port.
// Optional REGDUMP_SKIP_ZERO_EN suppresses beats for registers that read as zero.
module regfile_dump #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  freeze,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;
  localparam logic [1:0] DONE_S = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      rf_addr   <= '0;
      freeze    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx     <= '0;
            rf_addr <= '0;
            freeze  <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
`ifdef REGDUMP_SKIP_ZERO_EN
          // Zero registers are skipped; out_index tells the consumer which ones remain.
          if (rf_data == '0) begin
            if (idx == LAST) begin
              freeze <= 1'b0;
              done   <= 1'b1;
              state  <= DONE_S;
            end else begin
              idx     <= idx + 1'b1;
              rf_addr <= idx + 1'b1;
            end
          end else begin
            out_data  <= rf_data;
            out_index <= idx;
            out_valid <= 1'b1;
            state     <= SEND;
          end
`else
          out_data  <= rf_data;
          out_index <= idx;
          out_valid <= 1'b1;
          state     <= SEND;
`endif
        end
        SEND: begin
          // Termination is checked before incrementing so idx never wraps.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST) begin
              freeze <= 1'b0;
              done   <= 1'b1;
              state  <= DONE_S;
            end else begin
              idx     <= idx + 1'b1;
              rf_addr <= idx + 1'b1;
              state   <= READ;
            end
          end
        end
        DONE_S:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
